fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 stall  input  1  downstream cannot accept a new instruction this cycle.
REQ-005 pc_src  input  1  redirect request (taken branch/jump).
REQ-006 pc_target  input  32  redirect address.
REQ-007 imem_req  output  1  fetch request to instruction memory.
REQ-008 imem_addr  output  32  fetch address, equal to the internal pc register.
REQ-009 imem_ready  input  1  imem_rdata is valid this cycle for the current request.
REQ-010 imem_rdata  input  32  fetched instruction word.
REQ-011 instr  output  32  registered instruction; instr[6:0] is the opcode fed to the main decoder.
REQ-012 op  output  7  equal to instr[6:0] at all times.
REQ-013 pc_out  output  32  address of the word held in instr.
REQ-014 pc_plus4  output  32  pc_out + 4, modulo 2^32.
REQ-015 instr_valid  output  1  instr holds a real fetched instruction.
REQ-016 misalign  output  1  one-cycle pulse on a redirect with pc_target[1:0] != 2'b00.
REQ-017 fetch_count  output  16  count of accepted fetches.

Function
REQ-018 Two states, BOOT and FETCH; BOOT SHALL last exactly one cycle after rst_n deasserts, then go to FETCH unconditionally.
REQ-019 In BOOT, imem_req SHALL be 0 and instr, instr_valid, pc SHALL hold their reset values.
REQ-020 In FETCH, imem_req SHALL be 1 when stall=0 and pc_src=0, else 0 (combinational).
REQ-021 Accepted fetch: FETCH, imem_ready=1, stall=0, pc_src=0; next cycle instr=imem_rdata, pc_out=old pc, instr_valid=1, pc=old pc+4, fetch_count+1.
REQ-022 Bubble: FETCH, stall=0, pc_src=0, imem_ready=0; next cycle instr=32'h0, instr_valid=0, pc unchanged, pc_out unchanged.
REQ-023 Stall: stall=1, pc_src=0; instr, pc_out, instr_valid, pc, fetch_count SHALL hold; imem_ready SHALL be ignored.
REQ-024 Redirect: pc_src=1 in FETCH; next cycle pc={pc_target[31:2],2'b00}, instr=32'h0, instr_valid=0; any imem_rdata that cycle discarded, fetch_count unchanged.
REQ-025 Redirect SHALL take priority over stall and imem_ready; pc_src in BOOT SHALL be ignored.
REQ-026 misalign SHALL be 1 in the cycle after a redirect with pc_target[1:0] != 0, 0 otherwise.
REQ-027 pc increment and pc_plus4 SHALL wrap 32'hFFFF_FFFC -> 32'h0000_0000 without error.
REQ-028 fetch_count SHALL wrap 16'hFFFF -> 16'h0000.
REQ-029 instr=32'h0 SHALL decode downstream as opcode 7'b0000000 (all controls inactive), so bubbles are safe.

Reset
REQ-030 When rst_n=0 at a rising edge: state=BOOT, pc=RESET_PC, instr=32'h0, instr_valid=0, pc_out=RESET_PC, misalign=0, fetch_count=0.
REQ-031 Reset SHALL override stall, pc_src and imem_ready, including mid-fetch; no partial update survives.
REQ-032 imem_req SHALL be 0 while rst_n=0.

Verification
REQ-033 Reset release, imem_ready=1, rdata=32'h0000_0013 constant -> imem_req=0 one cycle, then imem_addr 0,4,8; instr_valid=1 from the 3rd edge; fetch_count 1,2,3.
REQ-034 imem_ready low 3 cycles at pc=8 -> instr=0, instr_valid=0, imem_addr held at 8 for 3 cycles; then ready -> instr=rdata, pc_out=8.
REQ-035 stall=1 for 2 cycles with instr=32'h0020_8033 at pc_out=4 -> instr, pc_out, fetch_count unchanged, imem_req=0.
REQ-036 pc_src=1, pc_target=32'h0000_0102, stall=1, imem_ready=1 same cycle -> next pc=32'h100, misalign=1 one cycle, instr=0, instr_valid=0, fetch_count unchanged.
REQ-037 pc=32'hFFFF_FFFC accepted fetch -> next imem_addr=0, pc_plus4=0; fetch_count at 16'hFFFF accepted fetch -> 16'h0000.
REQ-038 rst_n=0 during a cycle with imem_ready=1 -> next cycle all outputs at REQ-030 values, one BOOT cycle then fetch from RESET_PC.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory fetch bus between the fetch unit (master) and instruction memory (slave).
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential pc, redirect, stall and bubble handling,
// registered instruction with its address and an accepted-fetch counter.
//
// state | meaning
// BOOT  | single idle cycle after reset release, no request issued
// FETCH | requesting at pc; accept, bubble, stall or redirect each cycle
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall,
    input  logic         pc_src,
    input  logic [31:0]  pc_target,
    fetch_unit_if.master imem,
    output logic [31:0]  instr,
    output logic [6:0]   op,
    output logic [31:0]  pc_out,
    output logic [31:0]  pc_plus4,
    output logic         instr_valid,
    output logic         misalign,
    output logic [15:0]  fetch_count
);

    typedef enum logic {BOOT, FETCH} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] instr_nxt, pc_out_nxt;
    logic        valid_nxt, misalign_nxt, req;
    logic [15:0] count_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            instr       <= 32'h0;
            instr_valid <= 1'b0;
            pc_out      <= RESET_PC;
            misalign    <= 1'b0;
            fetch_count <= 16'h0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            instr       <= instr_nxt;
            instr_valid <= valid_nxt;
            pc_out      <= pc_out_nxt;
            misalign    <= misalign_nxt;
            fetch_count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        instr_nxt    = instr;
        valid_nxt    = instr_valid;
        pc_out_nxt   = pc_out;
        misalign_nxt = 1'b0;
        count_nxt    = fetch_count;
        req          = 1'b0;
        case (state)
            BOOT: state_nxt = FETCH;
            FETCH: begin
                req = !stall && !pc_src;
                // Redirect wins over stall and any data returned this cycle.
                if (pc_src) begin
                    pc_nxt       = {pc_target[31:2], 2'b00};
                    instr_nxt    = 32'h0;
                    valid_nxt    = 1'b0;
                    misalign_nxt = |pc_target[1:0];
                end else if (!stall) begin
                    if (imem.imem_ready) begin
                        instr_nxt  = imem.imem_rdata;
                        pc_out_nxt = pc;
                        valid_nxt  = 1'b1;
                        pc_nxt     = pc + 32'd4;
                        count_nxt  = fetch_count + 16'd1;
                    end else begin
                        instr_nxt = 32'h0;
                        valid_nxt = 1'b0;
                    end
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

    assign imem.imem_req  = req && rst_n;
    assign imem.imem_addr = pc;
    assign op             = instr[6:0];
    assign pc_plus4       = pc_out + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// compared against a behavioural fetch model.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n, stall, pc_src;
    logic [31:0] pc_target;
    logic [31:0] instr, pc_out, pc_plus4;
    logic [6:0]  op;
    logic        instr_valid, misalign;
    logic [15:0] fetch_count;

    fetch_unit_if imem_if ();

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .pc_src     (pc_src),
        .pc_target  (pc_target),
        .imem       (imem_if.master),
        .instr      (instr),
        .op         (op),
        .pc_out     (pc_out),
        .pc_plus4   (pc_plus4),
        .instr_valid(instr_valid),
        .misalign   (misalign),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit          m_init = 1'b0;
    bit          m_boot;
    logic [31:0] m_pc, m_instr, m_pc_out;
    bit          m_valid, m_mis;
    logic [15:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit s, input bit j, input logic [31:0] tgt,
                        input bit rdy, input logic [31:0] rd);
        bit exp_req;
        @(negedge clk);
        rst_n              = r;
        stall              = s;
        pc_src             = j;
        pc_target          = tgt;
        imem_if.imem_ready = rdy;
        imem_if.imem_rdata = rd;
        #1;
        exp_req = r && m_init && !m_boot && !s && !j;
        check("imem_req", imem_if.imem_req, exp_req);
        if (m_init) check("imem_addr_pre", imem_if.imem_addr, m_pc);
        @(posedge clk);
        if (!r) begin
            m_init = 1'b1; m_boot = 1'b1; m_pc = RESET_PC; m_instr = 32'h0;
            m_valid = 1'b0; m_pc_out = RESET_PC; m_mis = 1'b0; m_cnt = 16'h0;
        end else if (m_boot) begin
            m_boot = 1'b0; m_mis = 1'b0;
        end else begin
            m_mis = 1'b0;
            if (j) begin
                m_pc    = tgt - (tgt % 4);
                m_instr = 32'h0;
                m_valid = 1'b0;
                m_mis   = (tgt % 4) != 0;
            end else if (!s) begin
                if (rdy) begin
                    m_instr  = rd;
                    m_pc_out = m_pc;
                    m_valid  = 1'b1;
                    m_pc     = m_pc + 32'd4;
                    m_cnt    = m_cnt + 16'd1;
                end else begin
                    m_instr = 32'h0;
                    m_valid = 1'b0;
                end
            end
        end
        #1;
        if (m_init) begin
            check("instr", instr, m_instr);
            check("op", op, m_instr % 128);
            check("pc_out", pc_out, m_pc_out);
            check("pc_plus4", pc_plus4, m_pc_out + 32'd4);
            check("instr_valid", instr_valid, m_valid);
            check("misalign", misalign, m_mis);
            check("fetch_count", fetch_count, m_cnt);
            check("imem_addr", imem_if.imem_addr, m_pc);
        end
    endtask

    initial begin
        // Reset held while memory answers
        step(0, 0, 0, 32'h0, 1, 32'hDEAD_BEEF);
        step(0, 1, 1, 32'h40, 1, 32'hDEAD_BEEF);
        check("rst_instr", instr, 32'h0);
        check("rst_pc_out", pc_out, RESET_PC);

        // Boot cycle then fetches at 0 and 4
        step(1, 0, 1, 32'h80, 1, 32'h0000_0013);
        check("boot_valid", instr_valid, 1'b0);
        check("boot_addr", imem_if.imem_addr, RESET_PC);
        step(1, 0, 0, 32'h0, 1, 32'h0000_0013);
        check("f0_valid", instr_valid, 1'b1);
        check("f0_cnt", fetch_count, 32'd1);
        step(1, 0, 0, 32'h0, 1, 32'h0020_8033);
        check("f1_pc_out", pc_out, 32'h4);
        check("f1_addr", imem_if.imem_addr, 32'h8);

        // Stall two cycles: everything holds, memory data ignored
        for (int i = 0; i < 2; i++) step(1, 1, 0, 32'h0, 1, 32'h1111_1111);
        check("stall_instr", instr, 32'h0020_8033);
        check("stall_cnt", fetch_count, 32'd2);

        // Three bubbles at pc=8, then accept
        for (int i = 0; i < 3; i++) step(1, 0, 0, 32'h0, 0, 32'h2222_2222);
        check("bubble_addr", imem_if.imem_addr, 32'h8);
        check("bubble_instr", instr, 32'h0);
        step(1, 0, 0, 32'h0, 1, 32'h0000_0093);
        check("after_bubble_pc_out", pc_out, 32'h8);
        check("after_bubble_instr", instr, 32'h0000_0093);

        // Redirect beats stall and ready; misaligned target
        step(1, 1, 1, 32'h0000_0102, 1, 32'h3333_3333);
        check("redir_addr", imem_if.imem_addr, 32'h100);
        check("redir_mis", misalign, 1'b1);
        check("redir_cnt", fetch_count, 32'd3);
        step(1, 0, 0, 32'h0, 1, 32'h0000_0113);
        check("mis_pulse_end", misalign, 1'b0);

        // pc wrap at top of address space
        step(1, 0, 1, 32'hFFFF_FFFC, 0, 32'h0);
        step(1, 0, 0, 32'h0, 1, 32'h0000_0193);
        check("wrap_addr", imem_if.imem_addr, 32'h0);
        check("wrap_pc_plus4", pc_plus4, 32'h0);

        // Run the counter up to its wrap point
        while (m_cnt != 16'hFFFF) step(1, 0, 0, 32'h0, 1, $urandom);
        step(1, 0, 0, 32'h0, 1, $urandom);
        check("cnt_wrap", fetch_count, 32'h0);

        // Randomized traffic, with occasional reset
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) >= 3,
                 $urandom_range(0, 99) < 25,
                 $urandom_range(0, 99) < 10,
                 $urandom,
                 $urandom_range(0, 99) < 70,
                 $urandom);
        end

        // Reset mid-fetch, then boot and fetch from RESET_PC
        step(1, 0, 0, 32'h0, 1, 32'h0000_0013);
        step(0, 0, 0, 32'h0, 1, 32'h5555_5555);
        check("r038_valid", instr_valid, 1'b0);
        check("r038_cnt", fetch_count, 32'h0);
        step(1, 0, 0, 32'h0, 1, 32'h6666_6666);
        step(1, 0, 0, 32'h0, 1, 32'h0000_0013);
        check("r038_pc_out", pc_out, RESET_PC);
        check("r038_cnt1", fetch_count, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
